// File: rtl/fan_ctrl_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fan_ctrl_scheduler
//  Description : Fan-control timing and sequencing. Prescales clk into the
//                PWM clock-enable, derives the PID sample tick from it, runs
//                the ADC start/wait/latch handshake on each tick and issues a
//                one-cycle PID clock-enable once a fresh sample is held.
//                Flags ADC timeouts and ticks that arrive while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_ctrl_scheduler #(
   parameter int ADC_BITWIDTH      = 8,
   parameter int PRESCALE_BITWIDTH = 8,
   parameter int PERIOD_BITWIDTH   = 12,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         enable_i,
   input  logic                         clear_i,
   input  logic [PRESCALE_BITWIDTH-1:0] pwm_prescale_i,
   input  logic [PERIOD_BITWIDTH-1:0]   pid_period_i,
   input  logic [ADC_BITWIDTH-1:0]      adc_data_i,
   input  logic                         adc_valid_i,
   output logic                         adc_start_o,
   output logic [ADC_BITWIDTH-1:0]      adc_value_o,
   output logic                         clk_en_PWM_o,
   output logic                         clk_en_PID_o,
   output logic                         busy_o,
   output logic                         fault_o,
   output logic                         overrun_o
);

   // Wait counter only needs to reach TIMEOUT_CYCLES-1
   localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] c_WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_START  = 2'd1;
   localparam logic [1:0] c_WAIT   = 2'd2;
   localparam logic [1:0] c_UPDATE = 2'd3;

   logic [1:0]                   state_q, state_d;
   logic [PRESCALE_BITWIDTH-1:0] pcnt_q, pcnt_d;
   logic [PERIOD_BITWIDTH-1:0]   tcnt_q, tcnt_d;
   logic [WCNT_W-1:0]            wcnt_q, wcnt_d;

   logic                         adc_start_q, adc_start_d;
   logic [ADC_BITWIDTH-1:0]      adc_value_q, adc_value_d;
   logic                         pwm_q, pwm_d;
   logic                         pid_q, pid_d;
   logic                         busy_q, busy_d;
   logic                         fault_q, fault_d;
   logic                         overrun_q, overrun_d;

   logic w_pmatch;
   logic w_tick;
   logic w_accept;
   logic w_timeout;
   logic w_overrun_set;

   // Match/tick/handshake events; all are suppressed while the scheduler is stopped
   always_comb begin
      w_pmatch      = enable_i && (pcnt_q == pwm_prescale_i);
      w_tick        = w_pmatch && (tcnt_q == pid_period_i);
      w_accept      = enable_i && (state_q == c_WAIT) && adc_valid_i;
      w_timeout     = enable_i && (state_q == c_WAIT) && !adc_valid_i &&
                      (wcnt_q == c_WCNT_LAST);
      w_overrun_set = w_tick && (state_q != c_IDLE);
   end

   // Prescaler, period and wait counters; counters wrap naturally at their width
   always_comb begin
      pcnt_d = pcnt_q;
      tcnt_d = tcnt_q;
      wcnt_d = '0;
      if (!enable_i) begin
         pcnt_d = '0;
         tcnt_d = '0;
      end else begin
         if (w_pmatch) begin
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
         if (w_tick) begin
            tcnt_d = '0;
         end else if (w_pmatch) begin
            tcnt_d = tcnt_q + 1'b1;
         end
         if (state_q == c_WAIT) begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end
   end

   // FSM next state; valid in the final wait cycle beats the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:   if (w_tick) state_d = c_START;
         c_START:  state_d = c_WAIT;
         c_WAIT: begin
            if (adc_valid_i) begin
               state_d = c_UPDATE;
            end else if (wcnt_q == c_WCNT_LAST) begin
               state_d = c_IDLE;
            end
         end
         c_UPDATE: state_d = c_IDLE;
         default:  state_d = c_IDLE;
      endcase
      if (!enable_i) begin
         state_d = c_IDLE;
      end
   end

   // Output next values derived from the upcoming state so every output is a flop
   always_comb begin
      adc_start_d = (state_d == c_START);
      pid_d       = (state_d == c_UPDATE);
      busy_d      = (state_d != c_IDLE);
      pwm_d       = w_pmatch;
      adc_value_d = w_accept ? adc_data_i : adc_value_q;
      fault_d     = fault_q;
      overrun_d   = overrun_q;
      if (clear_i) begin
         fault_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (w_timeout) begin
         fault_d = 1'b1;
      end
      if (w_overrun_set) begin
         overrun_d = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pcnt_q <= '0;
         tcnt_q <= '0;
         wcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         tcnt_q <= tcnt_d;
         wcnt_q <= wcnt_d;
      end
   end

   // Output registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         adc_start_q <= 1'b0;
         adc_value_q <= '0;
         pwm_q       <= 1'b0;
         pid_q       <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         adc_start_q <= adc_start_d;
         adc_value_q <= adc_value_d;
         pwm_q       <= pwm_d;
         pid_q       <= pid_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         overrun_q   <= overrun_d;
      end
   end

   assign adc_start_o  = adc_start_q;
   assign adc_value_o  = adc_value_q;
   assign clk_en_PWM_o = pwm_q;
   assign clk_en_PID_o = pid_q;
   assign busy_o       = busy_q;
   assign fault_o      = fault_q;
   assign overrun_o    = overrun_q;

endmodule
`default_nettype wire
